hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It drives the PC enable and the per-stage `en` and `clear` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles four events: load-use stalls, branch-mispredict flushes, data-memory wait freezes and program halt. It also keeps saturating performance counters.

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, mispredict flushes,
// data-memory wait freezes, halt handling and saturating performance counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regfile_w_en,
    input  logic             ex_r_datamem,
    input  logic             ex_mispredict,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_in,
    input  logic             resume,
    output logic             pc_en,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             clear_ifid,
    output logic             clear_idex,
    output logic             clear_exmem,
    output logic             clear_memwb,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    // Wide enough that TIMEOUT + 1 never wraps.
    localparam int unsigned ToW = $clog2(TIMEOUT + 2);
    localparam logic [ToW-1:0] ToLim = ToW'(TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

    state_e           r_state, w_state_d;
    logic [ToW-1:0]   r_to_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;

    logic w_lu, w_mw, w_run, w_hold;
    logic w_do_halt, w_do_frz, w_do_flush, w_do_stall, w_to_fire;

    assign w_lu = ex_r_datamem && ex_regfile_w_en && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign w_mw = mem_req && !mem_ready;

    // An ongoing freeze is not interrupted; everything else uses the RUN priority order.
    assign w_run      = (r_state != StHalted);
    assign w_hold     = (r_state == StMemWait) && w_mw;
    assign w_do_halt  = w_run && halt_in && !w_hold;
    assign w_do_frz   = w_run && w_mw && !w_do_halt;
    assign w_do_flush = w_run && !halt_in && !w_mw && ex_mispredict;
    assign w_do_stall = w_run && !halt_in && !w_mw && !ex_mispredict && w_lu;
    assign w_to_fire  = (TIMEOUT != 0) && w_mw && ((r_to_cnt + ToW'(1)) == ToLim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StRun;
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_state_d;
            if (!w_mw) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != ToLim) begin
                r_to_cnt <= r_to_cnt + ToW'(1);
            end
            if (w_to_fire) begin
                r_timeout <= 1'b1;
            end
            if (w_do_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_do_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_do_frz && (r_wait_cnt != '1)) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun, StMemWait: begin
                if (w_do_halt) begin
                    w_state_d = StHalted;
                end else if (w_do_frz) begin
                    w_state_d = StMemWait;
                end else begin
                    w_state_d = StRun;
                end
            end
            StHalted: begin
                if (resume && !r_timeout) begin
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StRun;
        endcase
        if (w_to_fire) begin
            w_state_d = StHalted;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        clear_ifid  = 1'b1;
        clear_idex  = 1'b1;
        clear_exmem = 1'b1;
        clear_memwb = 1'b1;
        if (rst) begin
            pc_en       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            en_exmem    = 1'b0;
            en_memwb    = 1'b0;
            clear_ifid  = 1'b0;
            clear_idex  = 1'b0;
            clear_exmem = 1'b0;
            clear_memwb = 1'b0;
        end else if (!w_run || w_do_halt || w_do_frz) begin
            pc_en    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
        end else if (w_do_flush) begin
            clear_ifid = 1'b0;
            clear_idex = 1'b0;
        end else if (w_do_stall) begin
            pc_en      = 1'b0;
            en_ifid    = 1'b0;
            clear_idex = 1'b0;
        end
    end

    assign halted      = (r_state == StHalted);
    assign mem_timeout = r_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign wait_cnt    = r_wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (CNT_W = 4, TIMEOUT = 4).
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam logic [8:0] CDef   = 9'b1_1111_1111;
    localparam logic [8:0] CFrz   = 9'b0_0000_1111;
    localparam logic [8:0] CStall = 9'b0_0111_1011;
    localparam logic [8:0] CFlush = 9'b1_1111_0011;
    localparam logic [8:0] CRst   = 9'b0_0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, ex_regfile_w_en, ex_r_datamem, ex_mispredict;
    logic          mem_req, mem_ready, halt_in, resume;
    logic          pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic          clear_ifid, clear_idex, clear_exmem, clear_memwb;
    logic          halted, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic [8:0]    ctrl;

    int checks = 0;
    int errors = 0;

    assign ctrl = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                   clear_ifid, clear_idex, clear_exmem, clear_memwb};

    hazard_ctrl #(.CNT_W(CW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_regfile_w_en(ex_regfile_w_en), .ex_r_datamem(ex_r_datamem),
        .ex_mispredict(ex_mispredict), .mem_req(mem_req), .mem_ready(mem_ready),
        .halt_in(halt_in), .resume(resume),
        .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
        .en_memwb(en_memwb), .clear_ifid(clear_ifid), .clear_idex(clear_idex),
        .clear_exmem(clear_exmem), .clear_memwb(clear_memwb),
        .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rd = 5'd0; ex_regfile_w_en = 1'b0; ex_r_datamem = 1'b0; ex_mispredict = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; halt_in = 1'b0; resume = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_rd = rd; ex_r_datamem = 1'b1; ex_regfile_w_en = 1'b1;
        id_rs = 5'd5; id_uses_rs = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        halt_in = 1'b1;
        #1;
        checks++;
        if (ctrl !== CRst) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, CRst);
        end
        @(posedge clk); #1;
        checks++;
        if ({halted, mem_timeout, stall_cnt, flush_cnt, wait_cnt} !== '0) begin
            errors++; $display("FAIL reset_regs: halted=%b to=%b s=%0d f=%0d w=%0d expected all 0",
                               halted, mem_timeout, stall_cnt, flush_cnt, wait_cnt);
        end
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (ctrl !== CDef) begin
            errors++; $display("FAIL run_default: got %b expected %b", ctrl, CDef);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use(5'd5);
        #1;
        checks++;
        if (ctrl !== CStall) begin
            errors++; $display("FAIL lu_ctrl: got %b expected %b", ctrl, CStall);
        end
        @(posedge clk); #1;
        idle();
        #1;
        checks++;
        if (stall_cnt !== 4'd1 || ctrl !== CDef) begin
            errors++; $display("FAIL lu_after: stall_cnt=%0d ctrl=%b expected 1 %b",
                               stall_cnt, ctrl, CDef);
        end
        load_use(5'd0);
        #1;
        checks++;
        if (ctrl !== CDef) begin
            errors++; $display("FAIL lu_rd0_ctrl: got %b expected %b", ctrl, CDef);
        end
        // Matching rt but rt not used: no hazard.
        load_use(5'd7);
        id_rt = 5'd7;
        #1;
        checks++;
        if (ctrl !== CDef) begin
            errors++; $display("FAIL lu_rt_unused: got %b expected %b", ctrl, CDef);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_no_count: stall_cnt=%0d expected 1", stall_cnt);
        end
        idle();
    endtask

    task automatic test_flush_vs_lu();
        do_reset();
        load_use(5'd5);
        ex_mispredict = 1'b1;
        #1;
        checks++;
        if (ctrl !== CFlush) begin
            errors++; $display("FAIL flush_ctrl: got %b expected %b", ctrl, CFlush);
        end
        @(posedge clk); #1;
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL flush_cnts: flush=%0d stall=%0d expected 1 0",
                               flush_cnt, stall_cnt);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_mispredict = (i == 2);
            #1;
            checks++;
            if (ctrl !== CFrz) begin
                errors++; $display("FAIL mw_freeze[%0d]: got %b expected %b", i, ctrl, CFrz);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (wait_cnt !== 4'd3 || halted !== 1'b0 || flush_cnt !== 4'd0) begin
            errors++; $display("FAIL mw_cnt: wait=%0d halted=%b flush=%0d expected 3 0 0",
                               wait_cnt, halted, flush_cnt);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== CFlush) begin
            errors++; $display("FAIL mw_release: got %b expected %b", ctrl, CFlush);
        end
        @(posedge clk); #1;
        idle();
        #1;
        checks++;
        if (flush_cnt !== 4'd1 || wait_cnt !== 4'd3 || ctrl !== CDef) begin
            errors++; $display("FAIL mw_after: flush=%0d wait=%0d ctrl=%b expected 1 3 %b",
                               flush_cnt, wait_cnt, ctrl, CDef);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (mem_timeout !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL to_early: to=%b halted=%b expected 0 0", mem_timeout, halted);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_timeout !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL to_fire: to=%b halted=%b expected 1 1", mem_timeout, halted);
        end
        idle();
        resume = 1'b1;
        #1;
        checks++;
        if (ctrl !== CFrz) begin
            errors++; $display("FAIL to_halt_ctrl: got %b expected %b", ctrl, CFrz);
        end
        @(posedge clk); #1;
        resume = 1'b0;
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL to_resume_ignored: halted=%b expected 1", halted);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || mem_timeout !== 1'b0 || ctrl !== CRst) begin
            errors++; $display("FAIL to_async_rst: halted=%b to=%b ctrl=%b expected 0 0 %b",
                               halted, mem_timeout, ctrl, CRst);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_halt();
        do_reset();
        halt_in = 1'b1;
        #1;
        checks++;
        if (ctrl !== CFrz) begin
            errors++; $display("FAIL halt_ctrl: got %b expected %b", ctrl, CFrz);
        end
        @(posedge clk); #1;
        halt_in = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || ctrl !== CFrz) begin
            errors++; $display("FAIL halt_state: halted=%b ctrl=%b expected 1 %b",
                               halted, ctrl, CFrz);
        end
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || ctrl !== CDef) begin
            errors++; $display("FAIL halt_resume: halted=%b ctrl=%b expected 0 %b",
                               halted, ctrl, CDef);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        load_use(5'd5);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_fill: stall_cnt=%0d expected 15", stall_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_hold: stall_cnt=%0d expected 15", stall_cnt);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_flush_vs_lu();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
